jk_counter_bank: RTL

//   WIDTH-bit register of JK cells with a shared mode select: per-bit JK operation,

---
 rtl/jk_pkg.sv | 31 +++
 rtl/jk_counter_bank_if.sv | 25 ++
 rtl/jk_cell.sv | 34 +++
 rtl/jk_counter_bank.sv | 94 +++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK counter bank: mode encodings and the
// per-cell j/k drive encoding used to steer each JK cell.
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } jk_mode_e;

  // {j,k} pairs as seen by a single cell
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_CLEAR  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  typedef struct packed {
    logic j;
    logic k;
  } jk_drive_t;

  // Steer one cell from its current value to a wanted value without toggling.
  function automatic jk_drive_t jk_encode(input logic cur_bit, input logic nxt_bit);
    jk_drive_t drv;
    drv.j = nxt_bit & ~cur_bit;
    drv.k = ~nxt_bit & cur_bit;
    return drv;
  endfunction

endpackage

// File: rtl/jk_counter_bank_if.sv
// Control and state bundle of the JK counter bank; clock and reset stay plain ports.
interface jk_counter_bank_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q1;
  logic             tc;

  modport master (
    output en, mode, j, k, d,
    input  q, q1, tc
  );

  modport slave (
    input  en, mode, j, k, d,
    output q, q1, tc
  );

endinterface

// File: rtl/jk_cell.sv
// Single JK storage bit with synchronous reset to a per-bit value.
module jk_cell
  import jk_pkg::*;
(
  input  logic c,
  input  logic rst,
  input  logic rst_val,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q1
);

  logic q_r;

  // JK state update; reset wins over any j/k combination
  always_ff @(posedge c) begin
    if (rst) begin
      q_r <= rst_val;
    end else begin
      case ({j, k})
        JK_HOLD:   q_r <= q_r;
        JK_CLEAR:  q_r <= 1'b0;
        JK_SET:    q_r <= 1'b1;
        JK_TOGGLE: q_r <= ~q_r;
        default:   q_r <= q_r;
      endcase
    end
  end

  assign q  = q_r;
  assign q1 = ~q_r;

endmodule

// File: rtl/jk_counter_bank.sv
// Multi-mode register of JK cells: per-bit JK, modulo up/down count, or parallel load.
// Every mode is reduced to per-cell j/k so the cells are the only state.
module jk_counter_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               MODULO    = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic              c,
  input  logic              rst,
  jk_counter_bank_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1'b1);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] q1_s;
  logic [WIDTH-1:0] next_word_s;
  logic [WIDTH-1:0] cell_j_s;
  logic [WIDTH-1:0] cell_k_s;
  logic             out_of_range_s;
  logic             at_top_s;
  logic             at_bottom_s;
  logic             tc_s;

  // Wrap conditions; a loaded out-of-range value counts as both top and bottom
  always_comb begin
    out_of_range_s = ({1'b0, q_s} >= MOD_W);
    at_top_s       = (q_s >= MAX_W);
    at_bottom_s    = (q_s == {WIDTH{1'b0}}) | out_of_range_s;
  end

  // Full-word target value for the word-oriented modes
  always_comb begin
    next_word_s = q_s;
    case (bus.mode)
      MODE_UP:   next_word_s = at_top_s ? {WIDTH{1'b0}} : (q_s + ONE_W);
      MODE_DOWN: next_word_s = at_bottom_s ? MAX_W : (q_s - ONE_W);
      MODE_LOAD: next_word_s = bus.d;
      default:   next_word_s = q_s;
    endcase
  end

  // Per-cell drive: JK mode passes j/k through, other modes steer toward next_word_s
  always_comb begin
    cell_j_s = {WIDTH{1'b0}};
    cell_k_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (!bus.en) begin
        cell_j_s[i] = 1'b0;
        cell_k_s[i] = 1'b0;
      end else if (bus.mode == MODE_JK) begin
        cell_j_s[i] = bus.j[i];
        cell_k_s[i] = bus.k[i];
      end else begin
        {cell_j_s[i], cell_k_s[i]} = jk_encode(q_s[i], next_word_s[i]);
      end
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .c       (c),
      .rst     (rst),
      .rst_val (RESET_VAL[gi]),
      .j       (cell_j_s[gi]),
      .k       (cell_k_s[gi]),
      .q       (q_s[gi]),
      .q1      (q1_s[gi])
    );
  end

  // Terminal count: high in the cycle before a wrap edge in the counting modes
  always_comb begin
    tc_s = 1'b0;
    if (bus.en && !rst) begin
      case (bus.mode)
        MODE_UP:   tc_s = at_top_s;
        MODE_DOWN: tc_s = at_bottom_s;
        default:   tc_s = 1'b0;
      endcase
    end else begin
      tc_s = 1'b0;
    end
  end

  assign bus.q  = q_s;
  assign bus.q1 = q1_s;
  assign bus.tc = tc_s;

endmodule
